// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding and
// the default operand width.
package mult_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_ripple.sv
// Combinational W-bit ripple-carry adder: {cout,s} = x + y + cin.
// One full-adder cell per bit, carries chained through c[].
module add_ripple #(
  parameter int W = 8
) (
  input  logic         cin,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  // Per-bit full adder; carry ripples from bit 0 upward.
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned WIDTH x WIDTH shift-add multiplier with valid/ready
// handshakes on both sides. One partial-product step per RUN cycle through
// a single ripple-carry adder; the adder carry shifts into the product MSB.
// Optional feature macro: MULT_ACCUM_EN adds acc_clr/acc and a running
// accumulator of every delivered product (modulo 2^(2*WIDTH)).
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
`ifdef MULT_ACCUM_EN
  ,
  input  logic               acc_clr,
  output logic [2*WIDTH-1:0] acc
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] m;      // multiplicand
  logic [WIDTH-1:0] a_r;    // upper product half
  logic [WIDTH-1:0] q;      // lower product half / remaining multiplier bits
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] add_y;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Skip the add when the current multiplier bit is 0: {c,s} = {0,A}.
  assign add_y = q[0] ? m : '0;

  add_ripple #(.W(WIDTH)) u_add (
    .cin  (1'b0),
    .x    (a_r),
    .y    (add_y),
    .s    (sum),
    .cout (cout)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign product   = {a_r, q};

  // Control FSM and datapath: load on accept, shift-add WIDTH times, hold in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m     <= '0;
      a_r   <= '0;
      q     <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m     <= a;
            a_r   <= '0;
            q     <= b;
            count <= CW'(WIDTH);
            state <= RUN;
          end
        end
        RUN: begin
          a_r   <= {cout, sum[WIDTH-1:1]};
          q     <= {sum[0], q[WIDTH-1:1]};
          count <= count - 1'b1;
          if (count == CW'(1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULT_ACCUM_EN
  logic hs;
  assign hs = out_valid && out_ready;

  // Running sum of delivered products; clear wins over the old value but
  // still captures a coincident product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            acc <= '0;
    else if (acc_clr && hs) acc <= product;
    else if (acc_clr)      acc <= '0;
    else if (hs)           acc <= acc + product;
  end
`endif

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult (WIDTH=8). Expected products come
// from plain a*b arithmetic; timing expectations from the handshake rules.
// Build with MULT_ACCUM_EN defined to also exercise the accumulator.
module tb_shift_add_mult;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;
`ifdef MULT_ACCUM_EN
  logic           acc_clr;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_m;
`endif

  int checks = 0;
  int errors = 0;

  shift_add_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
`ifdef MULT_ACCUM_EN
    ,
    .acc_clr   (acc_clr),
    .acc       (acc)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: full-width unsigned product.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    return (2*W)'(x) * (2*W)'(y);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair (block assumed idle), then wait for out_valid.
  // lat = clock edges from the accept edge until out_valid is seen; -1 on timeout.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, output int lat);
    a = xa; b = xb; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 60) begin
      step();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
`ifdef MULT_ACCUM_EN
    acc_clr = 1'b0;
`endif
    repeat (3) step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
    checks++;
    if (product !== '0) begin
      errors++;
      $display("FAIL reset_product: got %h want 0", product);
    end
`ifdef MULT_ACCUM_EN
    checks++;
    if (acc !== '0) begin
      errors++;
      $display("FAIL reset_acc: got %h want 0", acc);
    end
`endif
    rst_n = 1'b1;
    step();
  endtask

  // 3*5: latency of WIDTH edges after accept (cycle WIDTH+1 counting the
  // accept cycle), one cycle wide with out_ready high.
  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    do_op(8'd3, 8'd5, lat);
    checks++;
    if (lat !== W) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges want %0d", lat, W);
    end
    checks++;
    if (product !== 16'h000F) begin
      errors++;
      $display("FAIL basic_product: got %h want 000f", product);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_pulse_width: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  // Corner operands, including the paths where the adder carry shifts in.
  task automatic test_corners();
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    int lat;
    ta[0] = 8'hFF; tb[0] = 8'hFF;
    ta[1] = 8'h80; tb[1] = 8'h02;
    ta[2] = 8'hFF; tb[2] = 8'h01;
    ta[3] = 8'h01; tb[3] = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], lat);
      checks++;
      if (lat !== W || product !== model(ta[i], tb[i])) begin
        errors++;
        $display("FAIL corner_%0d: %h*%h got %h lat %0d want %h lat %0d",
                 i, ta[i], tb[i], product, lat, model(ta[i], tb[i]), W);
      end
      step();
    end
  endtask

  // Zero multiplicand keeps full latency; in_valid held high with changing
  // operands during RUN must not cause a second accept or corrupt the result.
  task automatic test_zero_hold();
    int  n = 0;
    bit  bad = 0;
    out_ready = 1'b1;
    a = 8'h00; b = 8'hA5; in_valid = 1'b1;
    step();
    while (!out_valid && n < 60) begin
      if (in_ready || !busy) bad = 1;
      a = W'($urandom); b = W'($urandom);
      step();
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (n !== W) begin
      errors++;
      $display("FAIL zero_latency: got %0d edges want %0d", n, W);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL zero_in_ready_in_run: in_ready high or busy low during RUN");
    end
    checks++;
    if (product !== '0) begin
      errors++;
      $display("FAIL zero_product: got %h want 0", product);
    end
    step();
  endtask

  // Backpressure: DONE holds with stable product for 20 cycles.
  task automatic test_backpressure();
    logic [W-1:0] xa, xb;
    int  lat;
    bit  bad = 0;
    xa = W'($urandom); xb = W'($urandom);
    out_ready = 1'b0;
    do_op(xa, xb, lat);
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== model(xa, xb)) bad = 1;
      step();
    end
    checks++;
    if (bad || lat !== W) begin
      errors++;
      $display("FAIL backpressure_hold: out_valid=%b in_ready=%b product=%h want 1 0 %h",
               out_valid, in_ready, product, model(xa, xb));
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  // Reset at RUN cycle 4 aborts; no stray out_valid; next op is clean.
  task automatic test_reset_mid_run();
    int lat;
    bit seen = 0;
    out_ready = 1'b1;
    a = 8'd55; b = 8'd77; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset_flags: out_valid=%b in_ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      if (out_valid) seen = 1;
      step();
    end
    checks++;
    if (seen || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun_no_result: out_valid seen=%0d in_ready=%b want 0 1", seen, in_ready);
    end
    do_op(8'd7, 8'd9, lat);
    checks++;
    if (product !== 16'h003F || lat !== W) begin
      errors++;
      $display("FAIL midrun_next_op: got %h lat %0d want 003f lat %0d", product, lat, W);
    end
    step();
  endtask

  // Continuous in_valid/out_ready: accepts every WIDTH+2 cycles, in order.
  task automatic test_back_to_back();
    logic [2*W-1:0] exp_q[$];
    int             acc_t[$];
    int             n = 0;
    bit             bad = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int c = 0; c < 4 * (W + 2); c++) begin
      if (in_ready) begin
        a = W'($urandom); b = W'($urandom);
        exp_q.push_back(model(a, b));
        acc_t.push_back(c);
      end
      step();
      if (out_valid) begin
        if (exp_q.size() == 0 || product !== exp_q[0]) bad = 1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 60) begin
      if (out_valid) begin
        if (product !== exp_q[0]) bad = 1;
        void'(exp_q.pop_front());
      end
      step();
      n++;
    end
    checks++;
    if (bad || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_products: data error=%0d left=%0d want 0 0", bad, exp_q.size());
    end
    checks++;
    if (acc_t.size() < 3 || acc_t[1] - acc_t[0] != W + 2 || acc_t[2] - acc_t[1] != W + 2) begin
      errors++;
      $display("FAIL b2b_spacing: accepts=%0d spacing=%0d want >=3 spacing %0d",
               acc_t.size(), (acc_t.size() >= 2) ? acc_t[1] - acc_t[0] : -1, W + 2);
    end
  endtask

`ifdef MULT_ACCUM_EN
  task automatic test_accum();
    int lat;
    out_ready = 1'b1;
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    do_op(8'd200, 8'd200, lat);
    step();
    do_op(8'd255, 8'd255, lat);
    step();
    checks++;
    if (acc !== 16'h9A41) begin
      errors++;
      $display("FAIL accum_wrap: got %h want 9a41", acc);
    end
    do_op(8'd2, 8'd3, lat);
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    checks++;
    if (acc !== 16'd6) begin
      errors++;
      $display("FAIL accum_clr_handshake: got %h want 0006", acc);
    end
  endtask
`endif

  // 1000 random pairs with random out_ready stalls.
  task automatic test_random();
    logic [W-1:0] xa, xb;
`ifdef MULT_ACCUM_EN
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    acc_m = '0;
`endif
    for (int k = 0; k < 1000; k++) begin
      int  n = 0;
      bit  done = 0;
      xa = W'($urandom); xb = W'($urandom);
      out_ready = 1'b0;
      while (!in_ready && n < 60) begin step(); n++; end
      a = xa; b = xb; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 0;
      while (!done && n < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          done = 1;
          checks++;
          if (product !== model(xa, xb)) begin
            errors++;
            $display("FAIL random_%0d: %h*%h got %h want %h", k, xa, xb, product, model(xa, xb));
          end
`ifdef MULT_ACCUM_EN
          acc_m = acc_m + model(xa, xb);
`endif
        end
        step();
        n++;
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL random_timeout_%0d: no out_valid within 200 cycles", k);
      end
    end
`ifdef MULT_ACCUM_EN
    checks++;
    if (acc !== acc_m) begin
      errors++;
      $display("FAIL random_acc: got %h want %h", acc, acc_m);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_zero_hold();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef MULT_ACCUM_EN
    test_accum();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
